// File: rtl/m_access_fsm.sv
// m_access_fsm
// Memory-side consumer of the directory-to-memory access register. Decodes a
// held request flit, runs a LINE_WORDS-beat line read or write against a
// single-port memory, builds the reply flit for the memory-to-directory path
// and pulses mem_done_access once the reply has been accepted.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   d_m_areg_flits      held request flit {cmd, src, tag, addr, line}
//   v_d_m_areg_flits    request valid (level, held until mem_done_access)
//   mem_done_access     one-cycle pulse, request consumed
//   mem_req/mem_we      beat request / write beat
//   mem_addr/mem_wdata  beat byte address / write word
//   mem_ready           beat accepted when mem_req && mem_ready
//   mem_rdata/rvalid    read word, valid one cycle after an accepted read beat
//   m_d_flits/v_m_d_flits  reply flit and its valid
//   m_d_ack             reply accepted when v_m_d_flits && m_d_ack
//   m_busy              FSM is not idle
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a request; latches src/tag/addr on valid
// WR    | issuing write beats, one word per accepted beat
// RD    | issuing read beats, collecting rvalid words into the reply
// RESP  | reply flit valid, waiting for m_d_ack
// DONE  | one-cycle mem_done_access pulse back to the request register

module m_access_fsm #(
  parameter int WORD_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int FLIT_W     = 176
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] d_m_areg_flits,
  input  logic              v_d_m_areg_flits,
  output logic              mem_done_access,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [WORD_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [FLIT_W-1:0] m_d_flits,
  output logic              v_m_d_flits,
  input  logic              m_d_ack,
  output logic              m_busy
);

  localparam int LINE_W     = WORD_W * LINE_WORDS;
  localparam int BEAT_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam int WORD_BYTES = WORD_W / 8;
  localparam int OFF_W      = $clog2(LINE_WORDS * WORD_BYTES);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

  localparam logic [3:0] CMD_RD  = 4'b0001;
  localparam logic [3:0] CMD_WR  = 4'b0010;
  localparam logic [3:0] REP_RD  = 4'b1001;
  localparam logic [3:0] REP_WR  = 4'b1010;
  localparam logic [3:0] REP_ERR = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RESP,
    S_DONE
  } state_t;

  state_t state, state_nx;

  // request flit fields
  logic [3:0]        in_cmd;
  logic [3:0]        in_src;
  logic [7:0]        in_tag;
  logic [31:0]       in_addr;
  logic [LINE_W-1:0] in_line;

  assign in_cmd  = d_m_areg_flits[FLIT_W-1  -: 4];
  assign in_src  = d_m_areg_flits[FLIT_W-5  -: 4];
  assign in_tag  = d_m_areg_flits[FLIT_W-9  -: 8];
  assign in_addr = d_m_areg_flits[FLIT_W-17 -: 32];
  assign in_line = d_m_areg_flits[LINE_W-1:0];

  logic [WORD_W-1:0] wr_words [LINE_WORDS];

  always_comb begin
    for (int i = 0; i < LINE_WORDS; i++) begin
      wr_words[i] = in_line[i*WORD_W +: WORD_W];
    end
  end

  // beat / receive bookkeeping
  logic [BEAT_W-1:0] beat;
  logic [BEAT_W-1:0] rcnt;
  logic              rd_issued;   // all read beats accepted, waiting on rvalid only

  // reply register
  logic [3:0]        rep_cmd;
  logic [3:0]        rep_src;
  logic [7:0]        rep_tag;
  logic [31:0]       rep_addr;
  logic [WORD_W-1:0] rep_words [LINE_WORDS];
  logic [LINE_W-1:0] rep_data;

  always_comb begin
    rep_data = '0;
    for (int i = 0; i < LINE_WORDS; i++) begin
      rep_data[i*WORD_W +: WORD_W] = rep_words[i];
    end
  end

  assign m_d_flits = {rep_cmd, rep_src, rep_tag, rep_addr, rep_data};

  // Beat address is taken from the latched address, line-aligned; the
  // request's low offset bits only travel back in the reply.
  logic [31:0] line_base;
  logic [31:0] beat_addr;

  assign line_base = {rep_addr[31:OFF_W], {OFF_W{1'b0}}};
  assign beat_addr = line_base + (32'(beat) * 32'(WORD_BYTES));

  assign m_busy = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat      <= '0;
      rcnt      <= '0;
      rd_issued <= 1'b0;
      rep_cmd   <= '0;
      rep_src   <= '0;
      rep_tag   <= '0;
      rep_addr  <= '0;
      for (int i = 0; i < LINE_WORDS; i++) begin
        rep_words[i] <= '0;
      end
    end else begin
      case (state)
        S_IDLE: begin
          beat      <= '0;
          rcnt      <= '0;
          rd_issued <= 1'b0;
          if (v_d_m_areg_flits) begin
            rep_src  <= in_src;
            rep_tag  <= in_tag;
            rep_addr <= in_addr;
            // Final reply command is known at decode; only read data is
            // filled in later, so the flit is complete on entry to RESP.
            case (in_cmd)
              CMD_RD:  rep_cmd <= REP_RD;
              CMD_WR:  rep_cmd <= REP_WR;
              default: rep_cmd <= REP_ERR;
            endcase
            for (int i = 0; i < LINE_WORDS; i++) begin
              rep_words[i] <= '0;
            end
          end
        end
        S_WR: begin
          if (mem_ready) begin
            beat <= beat + 1'b1;
          end
        end
        S_RD: begin
          if (mem_req && mem_ready) begin
            beat <= beat + 1'b1;
            if (beat == LAST_BEAT) begin
              rd_issued <= 1'b1;
            end
          end
          if (mem_rvalid) begin
            rep_words[rcnt] <= mem_rdata;
            rcnt            <= rcnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx        = state;
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    v_m_d_flits     = 1'b0;
    mem_done_access = 1'b0;

    case (state)
      S_IDLE: begin
        if (v_d_m_areg_flits) begin
          case (in_cmd)
            CMD_RD:  state_nx = S_RD;
            CMD_WR:  state_nx = S_WR;
            default: state_nx = S_RESP;
          endcase
        end
      end
      S_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = beat_addr;
        mem_wdata = wr_words[beat];
        if (mem_ready && (beat == LAST_BEAT)) begin
          state_nx = S_RESP;
        end
      end
      S_RD: begin
        if (!rd_issued) begin
          mem_req  = 1'b1;
          mem_addr = beat_addr;
        end
        if (mem_rvalid && (rcnt == LAST_BEAT)) begin
          state_nx = S_RESP;
        end
      end
      S_RESP: begin
        v_m_d_flits = 1'b1;
        if (m_d_ack) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        mem_done_access = 1'b1;
        state_nx        = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_m_access_fsm.sv
// tb_m_access_fsm
// Scoreboarded bench for m_access_fsm. Each issued access pushes its expected
// memory beats and expected reply flit, computed from a line-level memory
// model; independent responder and reply-monitor processes pop and compare.

module tb_m_access_fsm;

  logic         clk = 1'b0;
  logic         rst;
  logic [175:0] d_m_areg_flits;
  logic         v_d_m_areg_flits;
  logic         mem_done_access;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_ready;
  logic [31:0]  mem_rdata;
  logic         mem_rvalid;
  logic [175:0] m_d_flits;
  logic         v_m_d_flits;
  logic         m_d_ack;
  logic         m_busy;

  always #5 clk = ~clk;

  m_access_fsm dut (
    .clk              (clk),
    .rst              (rst),
    .d_m_areg_flits   (d_m_areg_flits),
    .v_d_m_areg_flits (v_d_m_areg_flits),
    .mem_done_access  (mem_done_access),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_ready        (mem_ready),
    .mem_rdata        (mem_rdata),
    .mem_rvalid       (mem_rvalid),
    .m_d_flits        (m_d_flits),
    .v_m_d_flits      (v_m_d_flits),
    .m_d_ack          (m_d_ack),
    .m_busy           (m_busy)
  );

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } beat_t;

  logic [175:0] exp_q [$];
  beat_t        beat_q [$];

  logic [31:0] ref_mem  [logic [31:0]];   // reference model view
  logic [31:0] phys_mem [logic [31:0]];   // responder's storage

  int n_checks = 0;
  int n_fail   = 0;
  int ack_delay = 0;
  int ready_mode = 0;   // 0 always ready, 1 random, 2 pattern 1,0,0
  int pcnt = 0;
  int done_cnt = 0;
  int req_cycles = 0;
  bit inject_rv = 1'b0;

  function automatic logic [31:0] init_val(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [31:0] phys_rd(input logic [31:0] a);
    return phys_mem.exists(a) ? phys_mem[a] : init_val(a);
  endfunction

  task automatic check(input string name, input logic [175:0] act, input logic [175:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a line access is four word operations on the
  // line-aligned address; reply = {code, src, tag, addr, data}.
  task automatic expect_access(input logic [3:0] cmd, input logic [3:0] src, input logic [7:0] tag,
                               input logic [31:0] addr, input logic [127:0] line);
    logic [31:0]  base;
    logic [127:0] rdata;
    logic [3:0]   rc;
    base  = addr & 32'hFFFF_FFF0;
    rdata = '0;
    if (cmd == 4'd1) begin
      rc = 4'h9;
      for (int i = 0; i < 4; i++) begin
        beat_q.push_back('{we: 1'b0, addr: base + 32'(4*i), data: 32'h0});
        rdata[32*i +: 32] = ref_rd(base + 32'(4*i));
      end
    end else if (cmd == 4'd2) begin
      rc = 4'hA;
      for (int i = 0; i < 4; i++) begin
        beat_q.push_back('{we: 1'b1, addr: base + 32'(4*i), data: line[32*i +: 32]});
        ref_mem[base + 32'(4*i)] = line[32*i +: 32];
      end
    end else begin
      rc = 4'hF;
    end
    exp_q.push_back({rc, src, tag, addr, rdata});
  endtask

  // exp_lat: rising edges from the one that samples valid up to and including
  // the one that enters DONE (-1 = don't care).
  task automatic do_access(input logic [3:0] cmd, input logic [3:0] src, input logic [7:0] tag,
                           input logic [31:0] addr, input logic [127:0] line,
                           input int ackd, input int rmode, input int exp_lat);
    int n;
    int d0;
    int r0;
    expect_access(cmd, src, tag, addr, line);
    @(negedge clk);
    ack_delay  = ackd;
    ready_mode = rmode;
    pcnt       = 0;
    d0         = done_cnt;
    r0         = req_cycles;
    d_m_areg_flits   = {cmd, src, tag, addr, line};
    v_d_m_areg_flits = 1'b1;
    n = 0;
    while (1) begin
      @(posedge clk);
      #1;
      n++;
      if (mem_done_access) break;
      if (n >= 300) begin
        n_checks++;
        n_fail++;
        $display("FAIL done_timeout: no done after %0d cycles, cmd %h", n, cmd);
        break;
      end
    end
    v_d_m_areg_flits = 1'b0;
    if (exp_lat >= 0) check("latency", 176'(n), 176'(exp_lat));
    repeat (2) @(negedge clk);
    check("done_once", 176'(done_cnt - d0), 176'd1);
    check("idle_after", 176'(m_busy), 176'd0);
    if (cmd != 4'd1 && cmd != 4'd2) check("no_req_illegal", 176'(req_cycles - r0), 176'd0);
  endtask

  // memory responder + beat scoreboard
  initial begin : responder
    bit          pend;
    logic [31:0] pend_d;
    bit          pstall;
    logic [31:0] paddr;
    logic [31:0] pwd;
    logic        pwe;
    bit          r;
    beat_t       b;
    pend = 1'b0; pend_d = '0; pstall = 1'b0; paddr = '0; pwd = '0; pwe = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_rvalid = pend || inject_rv;
      mem_rdata  = pend ? pend_d : 32'hDEAD_BEEF;
      pend = 1'b0;
      inject_rv = 1'b0;
      case (ready_mode)
        0:       r = 1'b1;
        1:       r = 1'($urandom_range(0, 1));
        default: r = (pcnt % 3 == 0);
      endcase
      pcnt++;
      mem_ready = r;
      if (!rst && pstall) begin
        check("stall_req", 176'(mem_req), 176'd1);
        check("stall_we", 176'(mem_we), 176'(pwe));
        check("stall_addr", 176'(mem_addr), 176'(paddr));
        check("stall_wdata", 176'(mem_wdata), 176'(pwd));
      end
      if (mem_req) req_cycles++;
      if (!rst && mem_req && mem_ready) begin
        if (beat_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: addr %h we %b, none expected", mem_addr, mem_we);
        end else begin
          b = beat_q.pop_front();
          check("beat_we", 176'(mem_we), 176'(b.we));
          check("beat_addr", 176'(mem_addr), 176'(b.addr));
          if (b.we) begin
            check("beat_wdata", 176'(mem_wdata), 176'(b.data));
            phys_mem[mem_addr] = mem_wdata;
          end else begin
            pend   = 1'b1;
            pend_d = phys_rd(mem_addr);
          end
        end
      end
      pstall = !rst && mem_req && !mem_ready;
      paddr  = mem_addr;
      pwd    = mem_wdata;
      pwe    = mem_we;
    end
  end

  // reply consumer + reply scoreboard + done-pulse checks
  initial begin : reply_monitor
    int vcnt;
    bit prev_acc;
    vcnt = 0;
    prev_acc = 1'b0;
    m_d_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_d_ack  = 1'b0;
        vcnt     = 0;
        prev_acc = 1'b0;
      end else begin
        if (mem_done_access) begin
          check("done_after_ack", 176'(prev_acc), 176'd1);
          done_cnt++;
        end
        prev_acc = 1'b0;
        if (v_m_d_flits) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_reply: flit %h, none expected", m_d_flits);
            m_d_ack = 1'b1;
          end else begin
            check("reply_flit", m_d_flits, exp_q[0]);
            m_d_ack = (vcnt >= ack_delay);
            vcnt++;
            if (m_d_ack) begin
              void'(exp_q.pop_front());
              prev_acc = 1'b1;
            end
          end
        end else begin
          m_d_ack = 1'b0;
          vcnt    = 0;
        end
      end
    end
  end

  initial begin : main
    logic [3:0]   c;
    logic [127:0] ln;
    bit           found;
    int           d0;
    rst = 1'b1;
    v_d_m_areg_flits = 1'b0;
    d_m_areg_flits   = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_busy", 176'(m_busy), 176'd0);
    check("rst_req", 176'({mem_req, mem_we, v_m_d_flits, mem_done_access}), 176'd0);
    check("rst_addr_wdata", 176'({mem_addr, mem_wdata}), 176'd0);
    check("rst_reply", m_d_flits, 176'd0);

    // directed read at 0x1234
    for (int i = 0; i < 4; i++) begin
      ref_mem[32'h1230 + 32'(4*i)]  = 32'hA0 + 32'(i);
      phys_mem[32'h1230 + 32'(4*i)] = 32'hA0 + 32'(i);
    end
    do_access(4'd1, 4'h5, 8'h3C, 32'h0000_1234, 128'h0, 0, 0, 7);

    // directed write at 0x100
    do_access(4'd2, 4'h2, 8'h81, 32'h0000_0100,
              {32'h44, 32'h33, 32'h22, 32'h11}, 0, 0, 6);

    // write with mem_ready 1,0,0,1,...
    do_access(4'd2, 4'h7, 8'h12, 32'h0000_0408,
              {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'hCAFE_0000}, 0, 2, -1);

    // reply held off for 5 cycles; read back the line just written
    do_access(4'd1, 4'h1, 8'hEE, 32'h0000_040C, 128'h0, 5, 0, 12);

    // illegal command
    do_access(4'b0111, 4'h9, 8'h55, 32'h0000_2000, 128'h0, 0, 0, 2);

    // reset during read beat 2
    expect_access(4'd1, 4'h3, 8'h77, 32'h0000_2000, 128'h0);
    @(negedge clk);
    ready_mode = 0;
    ack_delay  = 0;
    d_m_areg_flits   = {4'd1, 4'h3, 8'h77, 32'h0000_2000, 128'h0};
    v_d_m_areg_flits = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #2;
      if (mem_req && mem_addr == 32'h0000_2008) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_reach_beat2", 176'(found), 176'd1);
    d0  = done_cnt;
    rst = 1'b1;
    v_d_m_areg_flits = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b0;
    beat_q.delete();
    exp_q.delete();
    check("midrst_busy", 176'(m_busy), 176'd0);
    check("midrst_outs", 176'({mem_req, mem_we, v_m_d_flits, mem_done_access}), 176'd0);
    check("midrst_addr_wdata", 176'({mem_addr, mem_wdata}), 176'd0);
    check("midrst_reply", m_d_flits, 176'd0);
    inject_rv = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("late_rvalid_busy", 176'(m_busy), 176'd0);
    check("late_rvalid_reply", m_d_flits, 176'd0);
    check("midrst_no_done", 176'(done_cnt - d0), 176'd0);
    do_access(4'd1, 4'h3, 8'h78, 32'h0000_2000, 128'h0, 0, 0, 7);

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      int r;
      int ackd;
      int rmode;
      int lat;
      r = $urandom_range(0, 9);
      if (r < 4) c = 4'd1;
      else if (r < 8) c = 4'd2;
      else begin
        do c = 4'($urandom_range(0, 15)); while (c == 4'd1 || c == 4'd2);
      end
      ln    = {$urandom, $urandom, $urandom, $urandom};
      ackd  = $urandom_range(0, 3);
      rmode = $urandom_range(0, 2);
      if (rmode == 0 && ackd == 0) lat = (c == 4'd1) ? 7 : (c == 4'd2) ? 6 : 2;
      else lat = -1;
      // small address pool so reads hit earlier writes
      do_access(c, 4'($urandom), 8'($urandom),
                {20'h0_0003, 8'($urandom_range(0, 7)), 4'($urandom)}, ln, ackd, rmode, lat);
    end

    check("exp_q_empty", 176'(exp_q.size()), 176'd0);
    check("beat_q_empty", 176'(beat_q.size()), 176'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
